mem_wb_stage: RTL and testbench

- MEM/WB pipeline boundary of the 5-stage MIPS32 core.
- Registers MEM-stage results and drives the register file write port (we/waddr/wdata) from WB.
- Owns the architectural HI/LO registers and the LL/SC link bit (LLbit), written at WB commit.
- Honours the pipeline-control stall vector and exception flush.

---
 rtl/mem_wb_stage.sv | 100 ++++++++++
 tb/tb_mem_wb_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: registers MEM results for register-file writeback,
// and owns the architectural HI/LO pair and the LL/SC link bit.
module mem_wb_stage #(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [REG_W-1:0]  mem_wdata,
  input  logic              mem_whilo,
  input  logic [REG_W-1:0]  mem_hi,
  input  logic [REG_W-1:0]  mem_lo,
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_value,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [REG_W-1:0]  wb_wdata,
  output logic              wb_whilo,
  output logic [REG_W-1:0]  wb_hi,
  output logic [REG_W-1:0]  wb_lo,
  output logic [REG_W-1:0]  hi_o,
  output logic [REG_W-1:0]  lo_o,
  output logic              llbit_o
);

  logic wb_llbit_we;
  logic wb_llbit_value;
  logic llbit_q;
  logic bubble;
  logic unused_stall;

  // Only the MEM and WB hold bits concern this boundary.
  assign unused_stall = ^stall[3:0];

  // An empty slot enters WB on flush, or when MEM is held but WB drains.
  assign bubble = flush | (stall[4] & ~stall[5]);

  // MEM -> WB pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd          <= '0;
      wb_wreg        <= 1'b0;
      wb_wdata       <= '0;
      wb_whilo       <= 1'b0;
      wb_hi          <= '0;
      wb_lo          <= '0;
      wb_llbit_we    <= 1'b0;
      wb_llbit_value <= 1'b0;
    end else if (bubble) begin
      wb_wd          <= '0;
      wb_wreg        <= 1'b0;
      wb_wdata       <= '0;
      wb_whilo       <= 1'b0;
      wb_hi          <= '0;
      wb_lo          <= '0;
      wb_llbit_we    <= 1'b0;
      wb_llbit_value <= 1'b0;
    end else if (!stall[4]) begin
      wb_wd          <= mem_wd;
      wb_wreg        <= mem_wreg;
      wb_wdata       <= mem_wdata;
      wb_whilo       <= mem_whilo;
      wb_hi          <= mem_hi;
      wb_lo          <= mem_lo;
      wb_llbit_we    <= mem_llbit_we;
      wb_llbit_value <= mem_llbit_value;
    end
  end

  // WB commit: HI/LO written as a pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wb_whilo) begin
      hi_o <= wb_hi;
      lo_o <= wb_lo;
    end
  end

  // WB commit: an exception breaks the LL/SC link even if WB is writing it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit_q <= 1'b0;
    end else if (flush) begin
      llbit_q <= 1'b0;
    end else if (wb_llbit_we) begin
      llbit_q <= wb_llbit_value;
    end
  end

  // SC in MEM must see an LL still sitting in WB, hence the bypass.
  assign llbit_o = flush       ? 1'b0 :
                   wb_llbit_we ? wb_llbit_value : llbit_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a per-cycle reference model of the WB slot,
// HI/LO and LLbit, plus hand-computed expectations at key points.
module tb_mem_wb_stage;
  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_llbit_we;
  logic        mem_llbit_value;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        llbit_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage #(.REG_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the instruction occupying WB, plus architectural state.
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llwe;
    logic        llv;
  } slot_t;

  slot_t       m_slot;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_ll;

  function automatic slot_t mem_slot();
    slot_t s;
    s.wd = mem_wd;       s.wreg = mem_wreg;  s.wdata = mem_wdata;
    s.whilo = mem_whilo; s.hi = mem_hi;      s.lo = mem_lo;
    s.llwe = mem_llbit_we; s.llv = mem_llbit_value;
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_slot <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_ll   <= 1'b0;
    end else begin
      if (m_slot.whilo) begin
        m_hi <= m_slot.hi;
        m_lo <= m_slot.lo;
      end
      if (flush)             m_ll <= 1'b0;
      else if (m_slot.llwe)  m_ll <= m_slot.llv;
      if (flush)             m_slot <= '0;          // exception: empty slot
      else if (!stall[4])    m_slot <= mem_slot();  // instruction advances
      else if (!stall[5])    m_slot <= '0;          // MEM held, WB drains
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model comparison every cycle while out of reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_wb_wd",    64'(wb_wd),    64'(m_slot.wd));
      chk("m_wb_wreg",  64'(wb_wreg),  64'(m_slot.wreg));
      chk("m_wb_wdata", 64'(wb_wdata), 64'(m_slot.wdata));
      chk("m_wb_whilo", 64'(wb_whilo), 64'(m_slot.whilo));
      chk("m_wb_hi",    64'(wb_hi),    64'(m_slot.hi));
      chk("m_wb_lo",    64'(wb_lo),    64'(m_slot.lo));
      chk("m_hi_o",     64'(hi_o),     64'(m_hi));
      chk("m_lo_o",     64'(lo_o),     64'(m_lo));
      chk("m_llbit_o",  64'(llbit_o),
          64'(flush ? 1'b0 : (m_slot.llwe ? m_slot.llv : m_ll)));
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wd"},    64'(wb_wd),    64'd0);
    chk({nm, "_wreg"},  64'(wb_wreg),  64'd0);
    chk({nm, "_wdata"}, 64'(wb_wdata), 64'd0);
    chk({nm, "_whilo"}, 64'(wb_whilo), 64'd0);
    chk({nm, "_wbhi"},  64'(wb_hi),    64'd0);
    chk({nm, "_wblo"},  64'(wb_lo),    64'd0);
    chk({nm, "_hi"},    64'(hi_o),     64'd0);
    chk({nm, "_lo"},    64'(lo_o),     64'd0);
    chk({nm, "_llbit"}, 64'(llbit_o),  64'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0;
    mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_whilo = 1'b0;
    mem_hi = '0; mem_lo = '0; mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;

    // Reset, then pass-through
    next(); next();
    chk_zero("rst");
    mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF;
    next();
    chk_zero("rst_edge");
    rst = 1'b1;
    next();
    chk("pass_wd",    64'(wb_wd),    64'd5);
    chk("pass_wreg",  64'(wb_wreg),  64'd1);
    chk("pass_wdata", 64'(wb_wdata), 64'hDEADBEEF);

    // MEM held, WB drains
    stall = 6'b010000;
    next();
    chk("bub_wreg",  64'(wb_wreg),  64'd0);
    chk("bub_wdata", 64'(wb_wdata), 64'd0);
    chk("bub_wd",    64'(wb_wd),    64'd0);

    // Both held: valid entry persists against changing MEM inputs
    stall = '0; mem_wd = 5'd7; mem_wdata = 32'h55;
    next();
    chk("cap_wd", 64'(wb_wd), 64'd7);
    stall = 6'b110000; mem_wd = 5'd9; mem_wdata = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      next();
      chk("hold_wd",    64'(wb_wd),    64'd7);
      chk("hold_wdata", 64'(wb_wdata), 64'h55);
      chk("hold_wreg",  64'(wb_wreg),  64'd1);
    end

    // HI/LO commit one edge after reaching WB
    stall = '0; mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
    mem_whilo = 1'b1; mem_hi = 32'h12345678; mem_lo = 32'h9ABCDEF0;
    next();
    chk("hl_wbhi",   64'(wb_hi),    64'h12345678);
    chk("hl_wblo",   64'(wb_lo),    64'h9ABCDEF0);
    chk("hl_whilo",  64'(wb_whilo), 64'd1);
    chk("hl_early",  64'(hi_o),     64'd0);
    mem_whilo = 1'b0; mem_hi = 32'hFFFFFFFF; mem_lo = 32'hFFFFFFFF;
    next();
    chk("hl_hi", 64'(hi_o), 64'h12345678);
    chk("hl_lo", 64'(lo_o), 64'h9ABCDEF0);
    next();
    chk("hl_hold_hi", 64'(hi_o), 64'h12345678);
    chk("hl_hold_lo", 64'(lo_o), 64'h9ABCDEF0);

    // LL: bypass while in WB, then from the register
    mem_hi = '0; mem_lo = '0;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    next();
    chk("ll_bypass", 64'(llbit_o), 64'd1);
    mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    next();
    chk("ll_reg", 64'(llbit_o), 64'd1);

    // Flush with an LL in WB, no stall, writing r31 from MEM
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    next();
    chk("ll_again", 64'(llbit_o), 64'd1);
    flush = 1'b1; mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    mem_wreg = 1'b1; mem_wd = 5'd31; mem_wdata = 32'h1234;
    #1;
    chk("fl_llbit_comb", 64'(llbit_o), 64'd0);
    next();
    chk("fl_wreg", 64'(wb_wreg), 64'd0);
    chk("fl_wd",   64'(wb_wd),   64'd0);
    flush = 1'b0;
    #1;
    chk("fl_llbit_reg", 64'(llbit_o), 64'd0);

    // Async reset with a live write in WB and HI committed
    mem_wd = 5'd3; mem_wdata = 32'h77; mem_whilo = 1'b1;
    mem_hi = 32'h1; mem_lo = 32'h2;
    next(); next();
    chk("ar_pre_hi",   64'(hi_o),    64'h1);
    chk("ar_pre_wreg", 64'(wb_wreg), 64'd1);
    rst = 1'b0;
    #1;
    chk_zero("async");
    rst = 1'b1;
    next();
    chk("ar_nowrite_hi", 64'(hi_o), 64'd0);
    chk("ar_nowrite_lo", 64'(lo_o), 64'd0);
    chk("ar_recapture",  64'(wb_whilo), 64'd1);
    mem_whilo = 1'b0; mem_wreg = 1'b0;
    next(); next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
